// File: rtl/zx_kbd_spi_matrix.sv
// ZX keyboard SPI slave: receives 48-bit key/status frames and serves the
// active-low 8x5 matrix to the port #FE read path, plus decoded control bits.
module zx_kbd_spi_matrix #(
    parameter int unsigned FRAME_BITS  = 48,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       CLK_14MHZ,
    input  logic       CPU_RESET,
    input  logic       KBD_CS,
    input  logic       KBD_CLK,
    input  logic       KBD_DI,
    input  logic [7:0] A_HI,
    output logic [4:0] KD,
    output logic       KBD_MAGIC,
    output logic       KBD_RESET_REQ,
    output logic       KBD_TURBO,
    output logic       FRAME_OK,
    output logic       FRAME_ERR
);

    localparam int unsigned KEYS   = FRAME_BITS - 8;
    localparam int unsigned CNT_W  = $clog2(FRAME_BITS + 2);
    localparam int unsigned WAIT_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_BITS + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(SYNC_STAGES);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT,
        CHECK
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] di_sync_q;
    logic                   clk_prev_q;

    logic cs_s;
    logic clk_s;
    logic di_s;
    logic clk_rise;

    state_t               state_q,  state_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [FRAME_BITS-1:0] sr_q,    sr_d;
    logic [WAIT_W-1:0]    wait_q,   wait_d;
    logic [KEYS-1:0]      key_q,    key_d;
    logic                 magic_q,  magic_d;
    logic                 rreq_q,   rreq_d;
    logic                 turbo_q,  turbo_d;
    logic                 ok_q,     ok_d;
    logic                 err_q,    err_d;

    always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
        if (!CPU_RESET) begin
            cs_sync_q  <= '1;
            clk_sync_q <= '0;
            di_sync_q  <= '0;
            clk_prev_q <= 1'b0;
        end else begin
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], KBD_CS};
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], KBD_CLK};
            di_sync_q  <= {di_sync_q[SYNC_STAGES-2:0], KBD_DI};
            clk_prev_q <= clk_s;
        end
    end

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign di_s     = di_sync_q[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_prev_q;

    always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
        if (!CPU_RESET) begin
            state_q <= WAIT_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            wait_q  <= '0;
            key_q   <= '1;
            magic_q <= 1'b0;
            rreq_q  <= 1'b0;
            turbo_q <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            wait_q  <= wait_d;
            key_q   <= key_d;
            magic_q <= magic_d;
            rreq_q  <= rreq_d;
            turbo_q <= turbo_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        wait_d  = wait_q;
        key_d   = key_q;
        magic_d = magic_q;
        rreq_d  = rreq_q;
        turbo_d = turbo_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            // The CS synchroniser resets high, so its output is trusted only
            // once real pin samples have flushed through every stage.
            WAIT_IDLE: begin
                if (wait_q != WAIT_MAX) begin
                    wait_d = wait_q + 1'b1;
                end else if (cs_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (!cs_s) begin
                    cnt_d   = '0;
                    sr_d    = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (clk_rise) begin
                    sr_d = {sr_q[FRAME_BITS-2:0], di_s};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (cs_s) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (cnt_q == CNT_FULL) begin
                    for (int unsigned k = 0; k < KEYS; k++) begin
                        key_d[k] = sr_q[FRAME_BITS-1-k];
                    end
                    magic_d = sr_q[7];
                    rreq_d  = sr_q[6];
                    turbo_d = sr_q[5];
                    ok_d    = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    // Selected rows are wired-ANDed; key_q[5*r + c] holds row r, column c.
    always_comb begin
        KD = '1;
        for (int unsigned r = 0; r < 8; r++) begin
            if (!A_HI[r]) begin
                KD = KD & key_q[5*r +: 5];
            end
        end
    end

    assign KBD_MAGIC     = magic_q;
    assign KBD_RESET_REQ = rreq_q;
    assign KBD_TURBO     = turbo_q;
    assign FRAME_OK      = ok_q;
    assign FRAME_ERR     = err_q;

endmodule

// File: tb/tb_zx_kbd_spi_matrix.sv
// Scoreboard bench for zx_kbd_spi_matrix: SPI frames in, matrix/status/pulses
// checked against a row/column model of the keyboard.
module tb_zx_kbd_spi_matrix;

    logic       clk;
    logic       rst_n;
    logic       cs;
    logic       sclk;
    logic       di;
    logic [7:0] a_hi;
    logic [4:0] kd;
    logic       magic, rreq, turbo, frame_ok, frame_err;

    zx_kbd_spi_matrix #(.FRAME_BITS(48), .SYNC_STAGES(2)) dut (
        .CLK_14MHZ    (clk),
        .CPU_RESET    (rst_n),
        .KBD_CS       (cs),
        .KBD_CLK      (sclk),
        .KBD_DI       (di),
        .A_HI         (a_hi),
        .KD           (kd),
        .KBD_MAGIC    (magic),
        .KBD_RESET_REQ(rreq),
        .KBD_TURBO    (turbo),
        .FRAME_OK     (frame_ok),
        .FRAME_ERR    (frame_err)
    );

    initial clk = 1'b0;
    always #35 clk = ~clk;

    typedef struct packed {
        logic            ok;
        logic [7:0][4:0] keys;
        logic [2:0]      st;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            mon_e;
    logic [7:0][4:0] key_m;
    logic [2:0]      st_m;
    int              vectors = 0;
    int              miscompares = 0;

    function automatic logic [4:0] model_kd(input logic [7:0][4:0] k, input logic [7:0] a);
        logic [4:0] res;
        res = 5'b11111;
        for (int r = 0; r < 8; r++) begin
            if (!a[r]) res = res & k[r];
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (frame_ok || frame_err) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse: ok=%0b err=%0b, expected no pulse", frame_ok, frame_err);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pulse_kind", {38'd0, frame_ok, frame_err}, {38'd0, mon_e.ok, ~mon_e.ok});
                chk("pulse_status", {37'd0, magic, rreq, turbo}, {37'd0, mon_e.st});
                chk("pulse_kd", {35'd0, kd}, {35'd0, model_kd(mon_e.keys, a_hi)});
            end
        end
    end

    task automatic send_bits(input logic [63:0] d, input int n);
        @(posedge clk);
        #17;
        cs = 1'b0;
        #280;
        for (int i = n - 1; i >= 0; i--) begin
            di = d[i];
            #140 sclk = 1'b1;
            #140 sclk = 1'b0;
        end
        #140 cs = 1'b1;
    endtask

    task automatic do_frame(input logic [63:0] d, input int n);
        exp_t e;
        if (n == 48) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 5; c++)
                    key_m[r][c] = d[47 - (5*r + c)];
            st_m = d[7:5];
            e.ok = 1'b1;
        end else begin
            e.ok = 1'b0;
        end
        e.keys = key_m;
        e.st   = st_m;
        exp_q.push_back(e);
        send_bits(d, n);
        for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(negedge clk);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL pulse_timeout: %0d pulses missing, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_all();
        logic [7:0] a;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: a = 8'hFF;
                1: a = 8'h00;
                2: a = 8'hFE;
                3: a = 8'h7F;
                default: a = 8'($urandom);
            endcase
            a_hi = a;
            #1;
            chk("sweep_kd", {35'd0, kd}, {35'd0, model_kd(key_m, a)});
        end
        chk("sweep_status", {37'd0, magic, rreq, turbo}, {37'd0, st_m});
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    initial begin
        logic [63:0]     d;
        logic [4:0]      old_kd, new_kd;
        logic [4:0]      samp[$];
        int              len, bad, seen_new;

        rst_n = 1'b0; cs = 1'b1; sclk = 1'b0; di = 1'b0; a_hi = 8'hFF;
        key_m = '1; st_m = '0;
        repeat (3) @(posedge clk);
        #17 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        a_hi = 8'hFE; #1;
        chk("reset_kd_FE", {35'd0, kd}, 40'h1F);
        a_hi = 8'h00; #1;
        chk("reset_kd_00", {35'd0, kd}, 40'h1F);
        chk("reset_status", {37'd0, magic, rreq, turbo}, 40'h0);
        chk("reset_pulses", {38'd0, frame_ok, frame_err}, 40'h0);

        // Only row 0 column 0 pressed, MAGIC set.
        d = 64'd0;
        d[47:0] = {1'b0, 39'h7F_FFFF_FFFF, 8'h80};
        do_frame(d, 48);
        a_hi = 8'hFE; #1;
        chk("f1_kd_FE", {35'd0, kd}, 40'h1E);
        a_hi = 8'hFD; #1;
        chk("f1_kd_FD", {35'd0, kd}, 40'h1F);
        chk("f1_magic", {39'd0, magic}, 40'h1);
        check_all();

        // Row 7 col 4 and row 3 col 2 pressed, TURBO set.
        d = 64'd0;
        d[47:0] = '1;
        d[8] = 1'b0;
        d[30] = 1'b0;
        d[7:0] = 8'h20;
        do_frame(d, 48);
        a_hi = 8'h77; #1;
        chk("f2_kd_77", {35'd0, kd}, 40'h0B);
        a_hi = 8'h00; #1;
        chk("f2_kd_00", {35'd0, kd}, 40'h0B);
        chk("f2_turbo", {39'd0, turbo}, 40'h1);
        check_all();

        // Wrong-length frames are discarded.
        d = {$urandom, $urandom};
        do_frame(d, 47);
        check_all();
        d = {$urandom, $urandom};
        do_frame(d, 49);
        check_all();
        do_frame(64'd0, 0);
        check_all();
        d = {$urandom, $urandom};
        do_frame(d, 60);
        check_all();

        for (int i = 0; i < 10; i++) begin
            d = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0, 1, 2, 3: len = 48;
                4:          len = ($urandom_range(0, 1) != 0) ? 47 : 49;
                default:    len = $urandom_range(0, 60);
            endcase
            do_frame(d, len);
            check_all();
        end

        // Reset in the middle of a frame; the remainder must be ignored.
        d = {$urandom, $urandom};
        @(posedge clk);
        #17 cs = 1'b0;
        #280;
        for (int i = 47; i >= 28; i--) begin
            di = d[i];
            #140 sclk = 1'b1;
            #140 sclk = 1'b0;
        end
        rst_n = 1'b0;
        key_m = '1;
        st_m = '0;
        #300 rst_n = 1'b1;
        for (int i = 27; i >= 0; i--) begin
            di = d[i];
            #140 sclk = 1'b1;
            #140 sclk = 1'b0;
        end
        #140 cs = 1'b1;
        repeat (15) @(negedge clk);
        check_all();
        d = {$urandom, $urandom};
        do_frame(d, 48);
        check_all();

        // Commit that flips every key: KD must step old->new in one edge.
        d = {$urandom, $urandom};
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++)
                d[47 - (5*r + c)] = ~key_m[r][c];
        @(negedge clk);
        a_hi = 8'hFE;
        old_kd = model_kd(key_m, 8'hFE);
        new_kd = ~old_kd;
        fork
            do_frame(d, 48);
            begin
                repeat (240) begin
                    @(negedge clk);
                    samp.push_back(kd);
                end
            end
        join
        bad = 0;
        seen_new = 0;
        foreach (samp[i]) begin
            if (samp[i] === new_kd) seen_new = 1;
            else if (!(samp[i] === old_kd && seen_new == 0)) bad++;
        end
        chk("glitch_bad_samples", 40'(bad), 40'd0);
        chk("glitch_final_kd", {35'd0, samp[samp.size() - 1]}, {35'd0, new_kd});
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
